mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single-port data/instruction `Memory` array between the instruction-fetch unit and the load/store unit. It drives the memory's `addr`/`width`/`we`/`write_data` inputs, captures `read_data` at the end of the access cycle, and returns a registered response to the winning requester. It also bounds-checks word addresses against the array depth and counts arbitration conflicts for the simulator's performance dump.

## Interface
- `N`, 12, log2 of memory depth in words; must match the memory instance.
- `DW`, 32, data width; only 32 is supported.
- `clk` input 1 system clock, rising edge.
- `rst_n` input 1 asynchronous active-low reset.
- `if_req` input 1 fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` input 32 fetch word address.
- `if_gnt` output 1 combinational grant; access performed this cycle.
- `if_rvalid` output 1 registered response valid, one cycle after `if_gnt`.
- `if_rdata` output 32 fetched word.
- `if_err` output 1 out-of-range address, qualified by `if_rvalid`.
- `ls_req` input 1 load/store request; held with its fields until `ls_gnt`.
- `ls_we` input 1 1 = store, 0 = load.
- `ls_addr` input 32 word address.
- `ls_width` input 3 funct3 encoding: bit0 = half, bit1 = word, else byte; bit2 = unsigned.
- `ls_wdata` input 32 store data.
- `ls_gnt` output 1 combinational grant.
- `ls_rvalid` output 1 registered response valid.
- `ls_rdata` output 32 load data, already extended by memory.
- `ls_err` output 1 out-of-range address, qualified by `ls_rvalid`.
- `mem_addr` output 32 to memory `addr`.
- `mem_width` output 3 to memory `width`.
- `mem_we` output 1 to memory `we`.
- `mem_wdata` output 32 to memory `write_data`.
- `mem_rdata` input 32 from memory `read_data` (combinational).
- `conflict_cnt` output 16 cycles with both `if_req` and `ls_req` high; saturating.

## Operation
- Priority state `last_ls` (1 bit): 1 = LSU was granted most recently. Reset value 1, so fetch wins the first conflict.
- Only one requester is active: that requester is granted.
- Both requesters are active: grant fetch if `last_ls`=1, else grant LSU. `last_ls` updates on every grant, not on idle cycles.
- No request: no grant, `mem_we`=0, `mem_addr`=0, `mem_width`=3'b010.
- Fetch grant: `mem_addr`=`if_addr`, `mem_width`=3'b010, `mem_we`=0.
- LSU grant: `mem_addr`=`ls_addr`, `mem_width`=`ls_width`, `mem_we`=`ls_we` & in-range.
- Range check: `addr >> N != 0` is out of range. The access is granted normally, but the write is suppressed, rdata returns 0, and `err`=1 with the response.
- Response registers: on a grant edge, capture `mem_rdata` (0 on error) into the granted port's rdata, set its rvalid, and clear the other port's rvalid. A store also returns rvalid, with rdata=0 as the write acknowledgement.
- rvalid is a one-cycle pulse per grant. rdata holds its value until the next grant to that port.
- `conflict_cnt` increments when both reqs are high, whether or not a grant is made, and saturates at 16'hFFFF.
- `mem_we` is forced 0 while `rst_n`=0.

## Timing
- Reset (asynchronous, immediate): all rvalid=0, err=0, rdata=0, `conflict_cnt`=0, `last_ls`=1. Grants are 0 while in reset.
- Grant latency is 0 cycles: gnt is combinational from req and `last_ls`.
- Response latency: a grant in cycle T gives rvalid in cycle T+1.
- Store commit happens at the rising edge that ends cycle T. A load to the same address at T+1 returns the new data.
- Back-to-back: a port may re-request in cycle T+1. Sustained throughput is 1 access per cycle in total.
- Under continuous conflict, grants strictly alternate between fetch and LSU.
- Reset asserted mid-access drops the pending response (no rvalid after release) and prevents the write.
- Requester fields that change while the request is not granted are unconstrained and must not affect state.

## Test plan
- Reset, then both reqs high in the same cycle (fetch addr 0x10, LSU load addr 0x20): fetch is granted in cycle 1 and LSU in cycle 2. `if_rvalid` is high in cycle 2 and `ls_rvalid` in cycle 3. `conflict_cnt`=1 after cycle 1.
- LSU store word 0xDEADBEEF to addr 5 in cycle T, then LSU load word from addr 5 in T+1: `ls_rdata`=0xDEADBEEF at T+2.
- Store byte 0x80 to addr 7, then load with `ls_width`=3'b000 → 0xFFFFFF80. Load with `ls_width`=3'b100 → 0x00000080.
- LSU store to addr 0x1000 (N=12): `mem_we` stays 0, `ls_err`=1 with `ls_rvalid`, and the contents of addr 0 are unchanged.
- Both reqs held high for 10 cycles: grants alternate F,L,F,L…, 5 each, and `conflict_cnt`=10.
- Assert `rst_n` low during a granted store cycle: no write occurs, and no rvalid appears after release. Force `conflict_cnt` near 16'hFFFF and confirm it saturates.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Grants are combinational, responses are registered, and out-of-range word addresses are flagged.
module mem_arbiter #(
    parameter int N  = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,

    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [31:0]   ls_addr,
    input  logic [2:0]    ls_width,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,

    output logic [31:0]   mem_addr,
    output logic [2:0]    mem_width,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [15:0]   conflict_cnt
);

    logic last_ls;
    logic both_req;
    logic if_oob;
    logic ls_oob;

    assign both_req = if_req & ls_req;
    assign if_oob   = (if_addr >> N) != 32'd0;
    assign ls_oob   = (ls_addr >> N) != 32'd0;

    // Gating with rst_n keeps grants, and therefore mem_we, low for the whole reset.
    assign if_gnt = rst_n & if_req & (~ls_req | last_ls);
    assign ls_gnt = rst_n & ls_req & (~if_req | ~last_ls);

    always_comb begin
        mem_addr  = 32'd0;
        mem_width = 3'b010;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_width = ls_width;
            mem_we    = ls_we & ~ls_oob;
            mem_wdata = ls_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ls <= 1'b1;
        end else if (if_gnt) begin
            last_ls <= 1'b0;
        end else if (ls_gnt) begin
            last_ls <= 1'b1;
        end
    end

    // A grant to one port ends any response pulse still showing on the other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if (if_gnt) begin
                if_rvalid <= 1'b1;
                if_err    <= if_oob;
                if_rdata  <= if_oob ? '0 : mem_rdata;
            end else if (ls_gnt) begin
                ls_rvalid <= 1'b1;
                ls_err    <= ls_oob;
                ls_rdata  <= (ls_oob || ls_we) ? '0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
        end else if (both_req && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word-indexed memory that honours width encodings.
module tb_mem_arbiter;

    localparam int N = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_width;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [2:0]  mem_width;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic [31:0] mem_arr [0:(1<<N)-1];
    bit          mem_loaded;
    logic [31:0] rd_word;

    int checks   = 0;
    int failures = 0;
    int if_count;
    int ls_count;

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_width     (ls_width),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .mem_addr     (mem_addr),
        .mem_width    (mem_width),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Memory preloads itself on the first edge (inside reset), then commits stores at each edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << N); i++) mem_arr[i] <= 32'hA000_0000 | i;
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            if (mem_width[1])      mem_arr[mem_addr[N-1:0]]       <= mem_wdata;
            else if (mem_width[0]) mem_arr[mem_addr[N-1:0]][15:0] <= mem_wdata[15:0];
            else                   mem_arr[mem_addr[N-1:0]][7:0]  <= mem_wdata[7:0];
        end
    end

    always_comb begin
        rd_word = mem_arr[mem_addr[N-1:0]];
        mem_rdata = rd_word;
        if (!mem_width[1]) begin
            if (mem_width[0])
                mem_rdata = mem_width[2] ? {16'd0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
            else
                mem_rdata = mem_width[2] ? {24'd0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
        end
    end

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic lr,
                                 input logic lwe, input logic [31:0] la, input logic [2:0] lw,
                                 input logic [31:0] lwd);
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_we    = lwe;
        ls_addr  = la;
        ls_width = lw;
        ls_wdata = lwd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 3'b010, 32'd0);
        checkOutput("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        checkOutput("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        tick();
        checkOutput("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_conflict", {16'd0, conflict_cnt}, 32'd0);

        // Cycle 1: both request, fetch wins the first conflict.
        rst_n = 1'b1;
        #1;
        checkOutput("c1_if_gnt", {31'd0, if_gnt}, 32'd1);
        checkOutput("c1_ls_gnt", {31'd0, ls_gnt}, 32'd0);
        checkOutput("c1_mem_addr", mem_addr, 32'h10);
        checkOutput("c1_mem_width", {29'd0, mem_width}, 32'd2);
        tick();
        checkOutput("c2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("c2_if_rdata", if_rdata, 32'hA000_0010);
        checkOutput("c2_if_err", {31'd0, if_err}, 32'd0);
        checkOutput("c2_conflict", {16'd0, conflict_cnt}, 32'd1);

        applyStimulus(1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 3'b010, 32'd0);
        checkOutput("c2_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        checkOutput("c2_mem_addr", mem_addr, 32'h20);
        tick();
        checkOutput("c3_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        checkOutput("c3_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("c3_ls_rdata", ls_rdata, 32'hA000_0020);
        checkOutput("c3_if_rdata_hold", if_rdata, 32'hA000_0010);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b010, 32'd0);
        checkOutput("idle_mem_addr", mem_addr, 32'd0);
        checkOutput("idle_mem_width", {29'd0, mem_width}, 32'd2);
        tick();
        checkOutput("idle_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);

        // Store word then load it back on the very next cycle.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'd5, 3'b010, 32'hDEAD_BEEF);
        checkOutput("sw_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("sw_ack_rvalid", {31'd0, ls_rvalid}, 32'd1);
        checkOutput("sw_ack_rdata", ls_rdata, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'd5, 3'b010, 32'd0);
        tick();
        checkOutput("lw_rdata", ls_rdata, 32'hDEAD_BEEF);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'd7, 3'b000, 32'h0000_0080);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'd7, 3'b000, 32'd0);
        tick();
        checkOutput("lb_rdata", ls_rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'd7, 3'b100, 32'd0);
        tick();
        checkOutput("lbu_rdata", ls_rdata, 32'h0000_0080);

        // Out-of-range store aliases onto index 0 in the memory, so it must not be written.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 3'b010, 32'h1234_5678);
        checkOutput("oob_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        checkOutput("oob_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        checkOutput("oob_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        checkOutput("oob_ls_err", {31'd0, ls_err}, 32'd1);
        checkOutput("oob_ls_rdata", ls_rdata, 32'd0);
        checkOutput("oob_mem0", mem_arr[0], 32'hA000_0000);

        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 3'b010, 32'd0);
        tick();
        checkOutput("oob_if_err", {31'd0, if_err}, 32'd1);
        checkOutput("oob_if_rdata", if_rdata, 32'd0);

        // Sustained conflict from a fresh reset alternates F,L,F,L...
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b010, 32'd0);
        rst_n = 1'b1;
        if_count = 0;
        ls_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'd2, 1'b1, 1'b0, 32'd3, 3'b010, 32'd0);
            checkOutput($sformatf("alt_if_gnt_%0d", i), {31'd0, if_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (if_gnt) if_count++;
            if (ls_gnt) ls_count++;
            tick();
        end
        checkOutput("alt_if_count", if_count, 32'd5);
        checkOutput("alt_ls_count", ls_count, 32'd5);
        checkOutput("alt_conflict", {16'd0, conflict_cnt}, 32'd10);

        // Reset lands in the middle of a granted store.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'd9, 3'b010, 32'hCAFE_F00D);
        checkOutput("mid_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("mid_ls_gnt_rst", {31'd0, ls_gnt}, 32'd0);
        tick();
        checkOutput("mid_mem9", mem_arr[9], 32'hA000_0009);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b010, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        checkOutput("mid_conflict", {16'd0, conflict_cnt}, 32'd0);

        applyStimulus(1'b1, 32'd1, 1'b1, 1'b0, 32'd1, 3'b010, 32'd0);
        repeat (65534) tick();
        checkOutput("sat_fffe", {16'd0, conflict_cnt}, 32'h0000_FFFE);
        tick();
        checkOutput("sat_ffff", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        tick();
        checkOutput("sat_hold", {16'd0, conflict_cnt}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
